imem_loadable: RTL and testbench
================================

IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 Parameter AW, default 8, word-address width; depth SHALL be 2**AW words.
REQ-002 Parameter DW, default 32, instruction word width; SHALL be a multiple of 8.
REQ-003 Parameter NOP, default 32'h8b1f03ff, word driven on q when no valid fetch exists.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 load_req  in  1  one-cycle request to enter program-load mode.
REQ-007 ld_valid  in  1  a load byte is present on ld_byte.
REQ-008 ld_byte  in  8  load data byte, least-significant byte of each word first.
REQ-009 ld_last  in  1  qualifies ld_valid; marks the final byte of the program.
REQ-010 ld_ready  out  1  loader accepts a byte this cycle.
REQ-011 addr  in  AW  fetch word address.
REQ-012 rd_en  in  1  fetch request.
REQ-013 stall  in  1  hold the current fetch output.
REQ-014 q  out  DW  registered instruction word.
REQ-015 q_valid  out  1  q holds a word read from memory.
REQ-016 state  out  2  00 IDLE, 01 LOAD, 10 RUN.
REQ-017 wcount  out  AW+1  number of words written by the last or current load.
REQ-018 ovf  out  1  sticky: a load byte was offered after memory was full.

Function
REQ-019 States: IDLE -> LOAD on load_req; LOAD -> RUN on an accepted byte with ld_last; RUN -> LOAD on load_req; load_req in LOAD SHALL be ignored.
REQ-020 Entering LOAD SHALL clear the byte lane counter, the write pointer, wcount, and ovf in the same edge.
REQ-021 ld_ready SHALL be 1 only in LOAD; a byte SHALL be accepted iff ld_valid & ld_ready; bytes offered outside LOAD SHALL be dropped.
REQ-022 Accepted bytes SHALL fill lanes 0..DW/8-1 of an assembly register; when the last lane fills, the word SHALL be written to mem[wptr] on that edge, wptr SHALL increment, and wcount SHALL increment.
REQ-023 ld_last on a partially filled word SHALL zero-fill the remaining lanes and write the word on that same edge.
REQ-024 When wcount equals 2**AW, further accepted bytes SHALL NOT write memory, SHALL set ovf, and ld_last SHALL still move the state to RUN; wptr SHALL NOT wrap.
REQ-025 Memory contents SHALL NOT be reset; uninitialised words SHALL read as 0.
REQ-026 In RUN, rd_en=1 with stall=0 SHALL register q <= mem[addr] and q_valid <= 1 (one-cycle latency).
REQ-027 In RUN, stall=1 SHALL hold q and q_valid unchanged regardless of rd_en and addr.
REQ-028 In RUN, rd_en=0 with stall=0 SHALL register q <= NOP and q_valid <= 0.
REQ-029 In IDLE and LOAD, q SHALL be NOP and q_valid 0 from the first edge in that state; stall SHALL have no effect.
REQ-030 A load_req in RUN on the same cycle as a fetch SHALL take priority: the fetch is discarded and q becomes NOP.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, q=NOP, q_valid=0, ld_ready=0, wcount=0, ovf=0, and clear wptr and the lane counter.
REQ-032 Reset during LOAD SHALL retain words already written and discard the partial assembly word.
REQ-033 After reset_n rises, the first state change SHALL occur on the first rising edge with load_req=1.

Verification
REQ-034 Reset, load_req, then bytes a3,28,00,91 with ld_last on the 4th -> mem[0]=32'h910028a3, wcount=1, state RUN; fetch addr 0 -> q=32'h910028a3 and q_valid=1 one cycle later.
REQ-035 Load of 6 bytes 01..06 with ld_last on 06 -> mem[0]=32'h04030201, mem[1]=32'h00000605, wcount=2.
REQ-036 In RUN, fetch addr 1, raise stall for 3 cycles while changing addr to 0 -> q held at mem[1] for the 3 cycles; after stall drops, q=mem[0] on the next edge.
REQ-037 AW=2: offer 17 bytes with ld_last on the 17th -> wcount=4, ovf=1, mem[0..3] hold bytes 1..16, state RUN.
REQ-038 Assert reset_n=0 after 2 bytes of the second word -> state IDLE, q=NOP asynchronously; mem[0] retained, mem[1] unchanged.
REQ-039 In RUN, load_req with rd_en=1 on the same cycle -> state LOAD, q=NOP, q_valid=0, wcount=0, ld_ready=1.

Source files
------------

// File: rtl/imem_loadable.sv
// Loadable instruction memory: a byte-serial loader assembles little-endian words
// into a 2**AW-word RAM, after which the core fetches registered words from it.
module imem_loadable #(
    parameter int            AW  = 8,
    parameter int            DW  = 32,
    parameter logic [DW-1:0] NOP = DW'(32'h8b1f03ff)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_req,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [AW-1:0] addr,
    input  logic          rd_en,
    input  logic          stall,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic [1:0]    state,
    output logic [AW:0]   wcount,
    output logic          ovf
);

    localparam int             LANES     = DW / 8;
    localparam int             LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);
    localparam logic [AW:0]    DEPTH     = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t        st;
    logic [DW-1:0] mem [2**AW];
    logic [LW-1:0] lane;
    logic [DW-1:0] asm_word;

    logic          accept;
    logic          full;
    logic          word_done;
    logic          mem_we;
    logic [DW-1:0] word_next;

    assign ld_ready  = (st == ST_LOAD);
    assign state     = st;
    assign accept    = ld_valid && ld_ready;
    assign full      = (wcount == DEPTH);
    // Unfilled upper lanes of asm_word are always zero, which gives the ld_last zero-fill.
    assign word_next = asm_word | (DW'(ld_byte) << {lane, 3'b000});
    assign word_done = (lane == LAST_LANE) || ld_last;
    // wcount doubles as the write pointer; writes stop once full, so it never wraps.
    assign mem_we    = accept && !full && word_done;

    // NOTE: the RAM has no reset so that loaded words survive reset_n and the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wcount[AW-1:0]] <= word_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= ST_IDLE;
            q        <= NOP;
            q_valid  <= 1'b0;
            wcount   <= '0;
            ovf      <= 1'b0;
            lane     <= '0;
            asm_word <= '0;
        end else begin
            if (st != ST_LOAD && load_req) begin
                st       <= ST_LOAD;
                wcount   <= '0;
                ovf      <= 1'b0;
                lane     <= '0;
                asm_word <= '0;
            end else if (accept) begin
                if (full) begin
                    ovf <= 1'b1;
                end else if (word_done) begin
                    wcount   <= wcount + 1'b1;
                    lane     <= '0;
                    asm_word <= '0;
                end else begin
                    lane     <= lane + 1'b1;
                    asm_word <= word_next;
                end
                if (ld_last) begin
                    st       <= ST_RUN;
                    lane     <= '0;
                    asm_word <= '0;
                end
            end

            // A load_req in RUN wins over a same-cycle fetch.
            if (st == ST_RUN && !load_req) begin
                if (!stall) begin
                    q       <= rd_en ? mem[addr] : NOP;
                    q_valid <= rd_en;
                end
            end else begin
                q       <= NOP;
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed scenarios plus randomized programs and fetch
// traffic, checked against a word-level model of the loaded program image.
module tb_imem_loadable;

    localparam int          AW    = 8;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h8b1f03ff;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_req;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_last;
    logic          ld_ready;
    logic [AW-1:0] addr;
    logic          rd_en;
    logic          stall;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [1:0]    state;
    logic [AW:0]   wcount;
    logic          ovf;

    imem_loadable #(.AW(AW), .DW(DW), .NOP(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .load_req(load_req), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready), .addr(addr),
        .rd_en(rd_en), .stall(stall), .q(q), .q_valid(q_valid), .state(state),
        .wcount(wcount), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];
    int          wcount_m;
    bit          ovf_m;
    logic [7:0]  prog [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Program image model: word w is bytes 4w..4w+3, LSB first, zero-padded.
    // A completed load writes the trailing partial word; an aborted one does not.
    task automatic model_load(input logic [7:0] b[$], input bit completed);
        int n;
        int words;
        logic [31:0] v;
        n        = b.size();
        words    = completed ? (n + 3) / 4 : n / 4;
        wcount_m = (words > DEPTH) ? DEPTH : words;
        ovf_m    = completed && (n > 4 * DEPTH);
        for (int w = 0; w < wcount_m; w++) begin
            v = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) v[8*k +: 8] = b[4*w + k];
            mem_m[w]   = v;
            known_m[w] = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 1'b0;
                ld_last  = 1'($urandom);
                stall    = 1'($urandom);
                rd_en    = 1'($urandom);
                tick();
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic enter_load(input string tag);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check({tag, "_state"}, state, 2'b01);
        check({tag, "_ready"}, ld_ready, 1'b1);
        check({tag, "_wcount"}, wcount, 0);
        check({tag, "_ovf"}, ovf, 1'b0);
        check({tag, "_q"}, q, NOP);
        check({tag, "_qv"}, q_valid, 1'b0);
    endtask

    // Full load; req_at >= 0 raises a (to-be-ignored) load_req alongside that byte.
    task automatic do_load(input string tag, input logic [7:0] b[$], input bit gaps, input int req_at);
        enter_load(tag);
        for (int i = 0; i < b.size(); i++) begin
            if (i == req_at) load_req = 1'b1;
            send_byte(b[i], i == b.size() - 1, gaps);
        end
        rd_en = 1'b0;
        stall = 1'b0;
        model_load(b, 1'b1);
        check({tag, "_run"}, state, 2'b10);
        check({tag, "_wcount_end"}, wcount, wcount_m);
        check({tag, "_ovf_end"}, ovf, ovf_m);
        check({tag, "_ready_end"}, ld_ready, 1'b0);
        check({tag, "_q_end"}, q, NOP);
    endtask

    task automatic fetch(input string tag, input int a);
        rd_en = 1'b1;
        stall = 1'b0;
        addr  = AW'(a);
        tick();
        check({tag, "_q"}, q, mem_m[a]);
        check({tag, "_qv"}, q_valid, 1'b1);
        rd_en = 1'b0;
    endtask

    task automatic random_prog(input int n);
        prog.delete();
        repeat (n) prog.push_back(8'($urandom));
    endtask

    initial begin
        logic [31:0] exp_q;
        bit          exp_v;
        int          a;

        reset_n = 1'b1; load_req = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        addr = '0; rd_en = 1'b0; stall = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("rst_state", state, 2'b00);
        check("rst_q", q, NOP);
        check("rst_qv", q_valid, 1'b0);
        check("rst_ready", ld_ready, 1'b0);
        check("rst_wcount", wcount, 0);
        check("rst_ovf", ovf, 1'b0);
        tick();
        reset_n = 1'b1;

        // IDLE ignores bytes and stays put until load_req.
        ld_valid = 1'b1; ld_last = 1'b1; rd_en = 1'b1; stall = 1'b1;
        repeat (3) tick();
        check("idle_state", state, 2'b00);
        check("idle_wcount", wcount, 0);
        check("idle_q", q, NOP);
        ld_valid = 1'b0; ld_last = 1'b0; rd_en = 1'b0; stall = 1'b0;

        prog = '{8'ha3, 8'h28, 8'h00, 8'h91};
        do_load("basic", prog, 1'b0, -1);
        check("basic_word", mem_m[0], 32'h910028a3);
        fetch("basic_f0", 0);

        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_load("partial", prog, 1'b1, -1);
        fetch("partial_f0", 0);
        fetch("partial_f1", 1);
        check("partial_w1", mem_m[1], 32'h00000605);

        // Stall holds the fetched word while addr and rd_en wander.
        fetch("stall_pre", 1);
        stall = 1'b1;
        addr  = '0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'($urandom);
            tick();
            check("stall_hold_q", q, mem_m[1]);
            check("stall_hold_qv", q_valid, 1'b1);
        end
        fetch("stall_post", 0);
        tick();
        check("nofetch_q", q, NOP);
        check("nofetch_qv", q_valid, 1'b0);

        // load_req mid-load is ignored.
        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        do_load("reqmid", prog, 1'b0, 5);
        fetch("reqmid_f2", 2);

        // Randomized programs followed by mixed fetch/stall traffic.
        for (int t = 0; t < 6; t++) begin
            random_prog($urandom_range(1, 40));
            do_load("rnd", prog, 1'b1, -1);
            exp_q = NOP;
            exp_v = 1'b0;
            for (int c = 0; c < 25; c++) begin
                stall = ($urandom_range(0, 3) == 0);
                rd_en = 1'($urandom);
                a     = $urandom_range(0, wcount_m - 1);
                addr  = AW'(a);
                tick();
                if (!stall) begin
                    exp_q = rd_en ? mem_m[a] : NOP;
                    exp_v = rd_en;
                end
                check("rnd_q", q, exp_q);
                check("rnd_qv", q_valid, exp_v);
            end
            stall = 1'b0;
            rd_en = 1'b0;
        end

        // Exactly full: no overflow; one byte more: overflow, no wrap.
        random_prog(4 * DEPTH);
        do_load("full", prog, 1'b0, -1);
        fetch("full_last", DEPTH - 1);
        random_prog(4 * DEPTH + 1);
        do_load("ovf", prog, 1'b0, -1);
        fetch("ovf_f0", 0);
        fetch("ovf_flast", DEPTH - 1);

        // Same-cycle load_req and fetch in RUN: the load wins.
        rd_en = 1'b1; addr = '0; load_req = 1'b1;
        tick();
        load_req = 1'b0; rd_en = 1'b0;
        check("pri_state", state, 2'b01);
        check("pri_q", q, NOP);
        check("pri_qv", q_valid, 1'b0);
        check("pri_wcount", wcount, 0);
        check("pri_ready", ld_ready, 1'b1);
        check("pri_ovf", ovf, 1'b0);

        // Reset mid-load after 3 words and 2 bytes: complete words survive.
        random_prog(14);
        for (int i = 0; i < 14; i++) send_byte(prog[i], 1'b0, 1'b0);
        a = mem_m[3];
        model_load(prog, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("rstload_state", state, 2'b00);
        check("rstload_q", q, NOP);
        check("rstload_ready", ld_ready, 1'b0);
        check("rstload_wcount", wcount, 0);
        #1 reset_n = 1'b1;
        tick();
        check("rstload_idle", state, 2'b00);
        prog = '{8'h5a};
        do_load("reload", prog, 1'b0, -1);
        fetch("reload_f0", 0);
        fetch("reload_f1", 1);
        fetch("reload_f2", 2);
        check("reload_f3_model", mem_m[3], 32'(a));
        fetch("reload_f3", 3);

        // Asynchronous reset while q holds a valid word.
        fetch("rstrun_pre", 2);
        #2 reset_n = 1'b0;
        #1;
        check("rstrun_q", q, NOP);
        check("rstrun_qv", q_valid, 1'b0);
        check("rstrun_state", state, 2'b00);
        #1 reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
